// File: rtl/loopback_link_ctrl.sv
// ---------------------------------------------------------------------------
// loopback_link_ctrl
//
// Bring-up and word-alignment controller for the HPIO TX->RX loopback link.
// Holds both HPIO blocks in reset, waits for PLL lock and the HPIO
// reset/VTC/delay sequencers, enables the counter data source, then finds
// the bit rotation that turns the RX parallel word back into the
// incrementing counter pattern and monitors the locked link for errors.
//
// Ports:
//   clk              fabric clock, rising edge
//   rst_n            asynchronous active-low reset
//   main_locked, tx_pll_locked, rx_pll_locked   PLL lock flags
//   tx_rst_seq_done, rx_rst_seq_done            HPIO reset sequencer done
//   tx_vtc_rdy, rx_vtc_rdy, tx_dly_rdy, rx_dly_rdy  HPIO ready flags
//   rx_data[7:0]     RX word, sampled only while rx_valid is high
//   rx_valid         RX read-data valid
//   retry            pulse, leaves FAIL
//   clear_err        pulse, zeroes err_cnt
//   hpio_rst         reset to both HPIO blocks
//   tx_en            counter data source enable
//   rot[2:0]         left rotation applied to rx_data
//   aligned          high while LOCKED
//   err_cnt[15:0]    saturating pattern-error count
//   fail             high while in FAIL
//   state[2:0]       FSM encoding for the ILA
// ---------------------------------------------------------------------------
module loopback_link_ctrl #(
   parameter int RST_CYCLES   = 16,
   parameter int LOCK_TIMEOUT = 65535,
   parameter int ALIGN_WINDOW = 32,
   parameter int ALIGN_SWEEPS = 4,
   parameter int LOSS_THRESH  = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        main_locked,
   input  logic        tx_pll_locked,
   input  logic        rx_pll_locked,
   input  logic        tx_rst_seq_done,
   input  logic        rx_rst_seq_done,
   input  logic        tx_vtc_rdy,
   input  logic        rx_vtc_rdy,
   input  logic        tx_dly_rdy,
   input  logic        rx_dly_rdy,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   input  logic        retry,
   input  logic        clear_err,
   output logic        hpio_rst,
   output logic        tx_en,
   output logic [2:0]  rot,
   output logic        aligned,
   output logic [15:0] err_cnt,
   output logic        fail,
   output logic [2:0]  state
);

   localparam logic [2:0] ST_RESET     = 3'd0;
   localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
   localparam logic [2:0] ST_WAIT_RDY  = 3'd2;
   localparam logic [2:0] ST_ALIGN     = 3'd3;
   localparam logic [2:0] ST_LOCKED    = 3'd4;
   localparam logic [2:0] ST_FAIL      = 3'd5;

   // Terminal counts: a transition fires on the edge where the counter
   // already holds (limit-1), so the limit equals the cycles/events spent.
   localparam logic [15:0] RST_LAST   = 16'(RST_CYCLES - 1);
   localparam logic [15:0] TMO_LAST   = 16'(LOCK_TIMEOUT - 1);
   localparam logic [7:0]  WIN_LAST   = 8'(ALIGN_WINDOW - 1);
   localparam logic [7:0]  SWEEP_LAST = 8'(ALIGN_SWEEPS - 1);
   localparam logic [7:0]  LOSS_LAST  = 8'(LOSS_THRESH - 1);

   // ------------------------------------------------------------------
   // State and counters
   // ------------------------------------------------------------------
   logic [2:0]  state_q,     state_d;
   logic [15:0] rst_cnt_q,   rst_cnt_d;
   logic [15:0] tmo_cnt_q,   tmo_cnt_d;
   logic [7:0]  good_cnt_q,  good_cnt_d;
   logic [7:0]  sweep_cnt_q, sweep_cnt_d;
   logic [7:0]  bad_cnt_q,   bad_cnt_d;
   logic [7:0]  prev_q,      prev_d;
   logic        prev_vld_q,  prev_vld_d;
   logic [2:0]  rot_q,       rot_d;
   logic [15:0] err_cnt_q,   err_cnt_d;
   logic        hpio_rst_q,  hpio_rst_d;
   logic        tx_en_q,     tx_en_d;
   logic        aligned_q,   aligned_d;
   logic        fail_q,      fail_d;

   logic        all_locked;
   logic        all_rdy;
   logic        lock_drop;
   logic [15:0] rot_dbl;
   logic [7:0]  word;
   logic [7:0]  prev_inc;
   logic        word_good;
   logic        err_inc;

   assign all_locked = main_locked & tx_pll_locked & rx_pll_locked;
   assign all_rdy    = tx_rst_seq_done & rx_rst_seq_done &
                       tx_vtc_rdy & rx_vtc_rdy & tx_dly_rdy & rx_dly_rdy;

   // Lock loss only matters once the link has been brought past WAIT_LOCK.
   assign lock_drop  = ~all_locked &
                       ((state_q == ST_WAIT_RDY) || (state_q == ST_ALIGN) ||
                        (state_q == ST_LOCKED));

   // Rotate-left by rot: the upper byte of the doubled word shifted left.
   assign rot_dbl   = {rx_data, rx_data} << rot_q;
   assign word      = rot_dbl[15:8];
   assign prev_inc  = prev_q + 8'd1;       // 8-bit wrap: 0xFF -> 0x00 is good
   assign word_good = (word == prev_inc);

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      rst_cnt_d   = rst_cnt_q;
      tmo_cnt_d   = tmo_cnt_q;
      good_cnt_d  = good_cnt_q;
      sweep_cnt_d = sweep_cnt_q;
      bad_cnt_d   = bad_cnt_q;
      prev_d      = prev_q;
      prev_vld_d  = prev_vld_q;
      rot_d       = rot_q;
      err_inc     = 1'b0;

      case (state_q)
         ST_RESET: begin
            if (rst_cnt_q == RST_LAST) begin
               state_d = ST_WAIT_LOCK;
            end else begin
               rst_cnt_d = rst_cnt_q + 16'd1;
            end
         end

         ST_WAIT_LOCK: begin
            if (all_locked) begin
               state_d = ST_WAIT_RDY;
            end else if (tmo_cnt_q == TMO_LAST) begin
               state_d = ST_FAIL;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 16'd1;
            end
         end

         ST_WAIT_RDY: begin
            if (all_rdy) begin
               state_d = ST_ALIGN;
            end else if (tmo_cnt_q == TMO_LAST) begin
               state_d = ST_FAIL;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 16'd1;
            end
         end

         ST_ALIGN: begin
            if (rx_valid) begin
               if (!prev_vld_q) begin
                  // First word at this rotation only seeds the comparison.
                  prev_d     = word;
                  prev_vld_d = 1'b1;
               end else if (word_good) begin
                  prev_d = word;
                  if (good_cnt_q == WIN_LAST) begin
                     state_d = ST_LOCKED;
                  end else begin
                     good_cnt_d = good_cnt_q + 8'd1;
                  end
               end else begin
                  // Try the next rotation; the stored word was taken under
                  // the old rotation, so it cannot be compared against.
                  good_cnt_d = 8'd0;
                  prev_vld_d = 1'b0;
                  rot_d      = rot_q + 3'd1;
                  if (rot_q == 3'd7) begin
                     if (sweep_cnt_q == SWEEP_LAST) begin
                        state_d = ST_FAIL;
                     end else begin
                        sweep_cnt_d = sweep_cnt_q + 8'd1;
                     end
                  end
               end
            end
         end

         ST_LOCKED: begin
            if (rx_valid) begin
               prev_d = word;
               if (word_good) begin
                  bad_cnt_d = 8'd0;
               end else begin
                  err_inc = 1'b1;
                  if (bad_cnt_q == LOSS_LAST) begin
                     state_d = ST_ALIGN;
                  end else begin
                     bad_cnt_d = bad_cnt_q + 8'd1;
                  end
               end
            end
         end

         ST_FAIL: begin
            if (retry) begin
               state_d = ST_RESET;
            end
         end

         default: begin
            state_d = ST_RESET;
         end
      endcase

      // Lock loss overrides everything decided above; the rotation found so
      // far is kept so re-alignment usually succeeds on the first try.
      if (lock_drop) begin
         state_d = ST_RESET;
         rot_d   = rot_q;
         prev_d  = prev_q;
         err_inc = 1'b0;
      end

      // Every state entry starts with fresh counters. Only the
      // ALIGN->LOCKED hand-off keeps the stored word valid.
      if (state_d != state_q) begin
         rst_cnt_d   = 16'd0;
         tmo_cnt_d   = 16'd0;
         good_cnt_d  = 8'd0;
         sweep_cnt_d = 8'd0;
         bad_cnt_d   = 8'd0;
         if (state_d != ST_LOCKED) begin
            prev_vld_d = 1'b0;
         end
      end
   end

   // clear_err wins over a same-cycle increment.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (clear_err) begin
         err_cnt_d = 16'd0;
      end else if (err_inc && (err_cnt_q != 16'hFFFF)) begin
         err_cnt_d = err_cnt_q + 16'd1;
      end
   end

   // Outputs are registered from the next state so they change together
   // with the state register.
   always_comb begin
      hpio_rst_d = (state_d == ST_RESET);
      tx_en_d    = (state_d == ST_ALIGN) || (state_d == ST_LOCKED);
      aligned_d  = (state_d == ST_LOCKED);
      fail_d     = (state_d == ST_FAIL);
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_RESET;
         rst_cnt_q   <= 16'd0;
         tmo_cnt_q   <= 16'd0;
         good_cnt_q  <= 8'd0;
         sweep_cnt_q <= 8'd0;
         bad_cnt_q   <= 8'd0;
         prev_q      <= 8'd0;
         prev_vld_q  <= 1'b0;
         rot_q       <= 3'd0;
         err_cnt_q   <= 16'd0;
         hpio_rst_q  <= 1'b1;
         tx_en_q     <= 1'b0;
         aligned_q   <= 1'b0;
         fail_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rst_cnt_q   <= rst_cnt_d;
         tmo_cnt_q   <= tmo_cnt_d;
         good_cnt_q  <= good_cnt_d;
         sweep_cnt_q <= sweep_cnt_d;
         bad_cnt_q   <= bad_cnt_d;
         prev_q      <= prev_d;
         prev_vld_q  <= prev_vld_d;
         rot_q       <= rot_d;
         err_cnt_q   <= err_cnt_d;
         hpio_rst_q  <= hpio_rst_d;
         tx_en_q     <= tx_en_d;
         aligned_q   <= aligned_d;
         fail_q      <= fail_d;
      end
   end

   assign hpio_rst = hpio_rst_q;
   assign tx_en    = tx_en_q;
   assign rot      = rot_q;
   assign aligned  = aligned_q;
   assign err_cnt  = err_cnt_q;
   assign fail     = fail_q;
   assign state    = state_q;

endmodule

// File: tb/tb_loopback_link_ctrl.sv
// ---------------------------------------------------------------------------
// tb_loopback_link_ctrl
//
// Directed bench for loopback_link_ctrl: bring-up timing, clean and rotated
// alignment, error counting and loss of alignment, clear_err priority,
// lock drop, asynchronous reset, sweep exhaustion and lock timeout.
// LOCK_TIMEOUT is shortened to keep the run short.
// ---------------------------------------------------------------------------
module tb_loopback_link_ctrl;

   localparam int TMO = 200;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        main_locked = 1'b1;
   logic        tx_pll_locked = 1'b1;
   logic        rx_pll_locked = 1'b1;
   logic        tx_rst_seq_done = 1'b1;
   logic        rx_rst_seq_done = 1'b1;
   logic        tx_vtc_rdy = 1'b1;
   logic        rx_vtc_rdy = 1'b1;
   logic        tx_dly_rdy = 1'b1;
   logic        rx_dly_rdy = 1'b1;
   logic [7:0]  rx_data = 8'd0;
   logic        rx_valid = 1'b0;
   logic        retry = 1'b0;
   logic        clear_err = 1'b0;
   logic        hpio_rst;
   logic        tx_en;
   logic [2:0]  rot;
   logic        aligned;
   logic [15:0] err_cnt;
   logic        fail;
   logic [2:0]  state;

   int err_count = 0;
   int chk_count = 0;

   always #5 clk = ~clk;

   loopback_link_ctrl #(
      .RST_CYCLES   (16),
      .LOCK_TIMEOUT (TMO),
      .ALIGN_WINDOW (32),
      .ALIGN_SWEEPS (4),
      .LOSS_THRESH  (4)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .main_locked     (main_locked),
      .tx_pll_locked   (tx_pll_locked),
      .rx_pll_locked   (rx_pll_locked),
      .tx_rst_seq_done (tx_rst_seq_done),
      .rx_rst_seq_done (rx_rst_seq_done),
      .tx_vtc_rdy      (tx_vtc_rdy),
      .rx_vtc_rdy      (rx_vtc_rdy),
      .tx_dly_rdy      (tx_dly_rdy),
      .rx_dly_rdy      (rx_dly_rdy),
      .rx_data         (rx_data),
      .rx_valid        (rx_valid),
      .retry           (retry),
      .clear_err       (clear_err),
      .hpio_rst        (hpio_rst),
      .tx_en           (tx_en),
      .rot             (rot),
      .aligned         (aligned),
      .err_cnt         (err_cnt),
      .fail            (fail),
      .state           (state)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_count++;
      if (got !== exp) begin
         err_count++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are read there.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] d);
      rx_data  = d;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   function automatic logic [7:0] rotr3(input logic [7:0] x);
      return {x[2:0], x[7:3]};
   endfunction

   // From RESET entry (or reset release) with all flags high:
   // 16 cycles of hpio_rst, then WAIT_LOCK, WAIT_RDY, ALIGN.
   task automatic bringup();
      repeat (15) tick();
      check("rst_hold_hpio", hpio_rst, 1);
      check("rst_hold_state", state, 0);
      tick();
      check("rst_end_hpio", hpio_rst, 0);
      check("wait_lock_state", state, 1);
      check("wait_lock_txen", tx_en, 0);
      tick();
      check("wait_rdy_state", state, 2);
      tick();
      check("align_state", state, 3);
      check("align_txen", tx_en, 1);
   endtask

   initial begin
      logic [7:0] c;

      // ---- power-on reset ----
      #1 rst_n = 1'b0;
      tick();
      tick();
      check("por_state", state, 0);
      check("por_hpio", hpio_rst, 1);
      check("por_txen", tx_en, 0);
      check("por_rot", rot, 0);
      check("por_aligned", aligned, 0);
      check("por_err", err_cnt, 0);
      check("por_fail", fail, 0);
      rst_n = 1'b1;

      // ---- clean counter, rot 0: LOCKED after 33 valid words ----
      bringup();
      c = 8'h20;
      for (int i = 1; i <= 33; i++) begin
         send(c);
         c = c + 8'd1;
         if (i == 32) begin
            check("clean_pre_aligned", aligned, 0);
            check("clean_pre_state", state, 3);
         end
      end
      check("clean_aligned", aligned, 1);
      check("clean_state", state, 4);
      check("clean_rot", rot, 0);

      // ---- LOCKED: 3 bad then good (prev=0x40) ----
      send(8'hAA);
      send(8'hAA);
      send(8'h43);
      send(8'h44);
      check("err3_cnt", err_cnt, 3);
      check("err3_state", state, 4);
      check("err3_aligned", aligned, 1);

      // bad word with simultaneous clear_err -> 0
      clear_err = 1'b1;
      send(8'hAA);
      clear_err = 1'b0;
      check("clr_coincide_err", err_cnt, 0);
      check("clr_coincide_state", state, 4);
      send(8'hAB);                       // good, clears bad count

      // 4 consecutive bad words -> back to ALIGN
      send(8'h00);
      send(8'h00);
      send(8'h00);
      check("loss3_state", state, 4);
      check("loss3_err", err_cnt, 3);
      send(8'h00);
      check("loss4_state", state, 3);
      check("loss4_aligned", aligned, 0);
      check("loss4_err", err_cnt, 4);
      check("loss4_rot", rot, 0);
      check("loss4_txen", tx_en, 1);

      clear_err = 1'b1;
      tick();
      clear_err = 1'b0;
      check("clr_idle_err", err_cnt, 0);

      // ---- counter rotated right by 3 ----
      c = 8'h10;
      for (int i = 1; i <= 39; i++) begin
         send(rotr3(c));
         c = c + 8'd1;
         if (i == 2) check("rot_step1", rot, 1);
         if (i == 4) check("rot_step2", rot, 2);
         if (i == 6) check("rot_step3", rot, 3);
         if (i == 38) check("rot_pre_aligned", aligned, 0);
      end
      check("rot_aligned", aligned, 1);
      check("rot_state", state, 4);
      check("rot_final", rot, 3);
      check("rot_err", err_cnt, 0);

      // ---- 1-cycle main_locked drop in LOCKED ----
      main_locked = 1'b0;
      tick();
      main_locked = 1'b1;
      check("drop_state", state, 0);
      check("drop_hpio", hpio_rst, 1);
      check("drop_txen", tx_en, 0);
      check("drop_aligned", aligned, 0);
      check("drop_rot_kept", rot, 3);
      bringup();
      check("drop_rot_after", rot, 3);

      // ---- asynchronous reset mid-operation ----
      rst_n = 1'b0;
      #2;
      check("async_state", state, 0);
      check("async_hpio", hpio_rst, 1);
      check("async_txen", tx_en, 0);
      check("async_rot", rot, 0);
      #2 rst_n = 1'b1;
      bringup();

      // ---- non-counter data: FAIL after 4 sweeps (64 words) ----
      for (int i = 1; i <= 63; i++) begin
         if (i == 10) retry = 1'b1;
         send(8'h00);
         retry = 1'b0;
         if (i == 10) check("retry_ignored", state, 3);
      end
      check("sweep_pre_state", state, 3);
      check("sweep_pre_rot", rot, 7);
      send(8'h00);
      check("sweep_fail_state", state, 5);
      check("sweep_fail", fail, 1);
      check("sweep_txen", tx_en, 0);
      check("sweep_hpio", hpio_rst, 0);
      check("sweep_rot", rot, 0);

      // ---- lock timeout with rx_pll_locked low ----
      rx_pll_locked = 1'b0;
      retry = 1'b1;
      tick();
      retry = 1'b0;
      check("retry_state", state, 0);
      check("retry_hpio", hpio_rst, 1);
      check("retry_fail", fail, 0);
      repeat (16) tick();
      check("tmo_wait_state", state, 1);
      repeat (TMO - 1) tick();
      check("tmo_pre_state", state, 1);
      tick();
      check("tmo_state", state, 5);
      check("tmo_fail", fail, 1);
      retry = 1'b1;
      tick();
      retry = 1'b0;
      check("tmo_retry_hpio", hpio_rst, 1);
      check("tmo_retry_state", state, 0);

      $display("Result: errors=%0d of %0d checks", err_count, chk_count);
      $finish;
   end

endmodule
